gng_stat_mon: RTL and testbench
===============================

GNG_STAT_MON -- requirements
Module: gng_stat_mon

Interface
REQ-001 SHALL have parameter LOG2_N, default 10, meaning log2 of the number of samples per measurement window (legal range 4..16).
REQ-002 SHALL have port i_clock  input  1  system clock, with all logic on its rising edge.
REQ-003 SHALL have port i_reset  input  1  synchronous reset, active low.
REQ-004 SHALL have port start  input  1  request one measurement window.
REQ-005 SHALL have port valid_in  input  1  data_in qualifier, driven from the noise generator's valid_out.
REQ-006 SHALL have port data_in  input  16  signed noise sample in s<16,11> format.
REQ-007 SHALL have port ce_out  output  1  clock enable to the noise generator's ce input.
REQ-008 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking mean_out and var_out as updated.
REQ-010 SHALL have port mean_out  output  16  signed window mean in s<16,11> format.
REQ-011 SHALL have port var_out  output  32  unsigned window variance in u<32,22> format.

Function
REQ-012 SHALL use the FSM states IDLE, ACCUM, MEAN, SQ and OUT.
REQ-013 SHALL move IDLE->ACCUM on the edge where start=1, and SHALL clear the sample counter, sum and sum-of-squares on that edge.
REQ-014 SHALL ignore start in every state other than IDLE, with no restart and no error.
REQ-015 SHALL drive ce_out=1 exactly while the state is ACCUM, and 0 otherwise.
REQ-016 SHALL, in ACCUM, accept a sample only on a cycle with valid_in=1; valid_in gaps stall accumulation without limit.
REQ-017 SHALL ignore valid_in/data_in outside ACCUM, including pipeline tail samples arriving after ce_out falls.
REQ-018 SHALL keep the sum as a signed (16+LOG2_N)-bit value, which cannot overflow.
REQ-019 SHALL keep the sum of squares as an unsigned (31+LOG2_N)-bit value; each square is data_in*data_in, exact, with -32768^2=2^30.
REQ-020 SHALL move ACCUM->MEAN on the edge accepting sample number 2^LOG2_N.
REQ-021 SHALL, in MEAN, register mean = sum >>> LOG2_N (arithmetic shift, floor) and msq = sumsq >> LOG2_N (u<31,22>).
REQ-022 SHALL, in SQ, register mean*mean (u<31,22>, exact).
REQ-023 SHALL, in OUT, compute var = msq - mean^2, clamped to 0 if negative, zero-extended to 32 bits.
REQ-024 SHALL update mean_out and var_out on the edge entering OUT, assert done=1 for that single cycle, and then return to IDLE.
REQ-025 SHALL assert done exactly 3 cycles after the cycle that accepted the last sample.
REQ-026 SHALL hold mean_out and var_out stable between done pulses.
REQ-027 SHALL allow a start presented during the OUT cycle to be ignored; the next start is accepted in IDLE on the following cycle.

Reset
REQ-028 SHALL, on i_reset=0 at a clock edge, set state=IDLE, ce_out=0, busy=0, done=0, mean_out=0, var_out=0, and clear the counter and accumulators.
REQ-029 SHALL, on reset mid-window (any state), abandon the window with no done pulse and leave prior results cleared.
REQ-030 SHALL give reset priority over start and valid_in on the same edge.

Structure
REQ-031 SHALL place the data width (16), fraction bits (11), variance width (32) and FSM state encodings in the shared GNG package/include, for reuse by the noise generator and the bench.
REQ-032 SHALL implement the counter, sum and sum-of-squares datapath in one sub-module, gng_stat_acc, with the FSM and result arithmetic in gng_stat_mon.
REQ-033 SHALL NOT register data_in outside the accept path, and SHALL NOT use a divider (shifts only).

Verification
REQ-034 SHALL cover: LOG2_N=4, 16 samples of 2048 (1.0) -> mean_out=2048, var_out=0, done 3 cycles after the 16th accept.
REQ-035 SHALL cover: LOG2_N=4, alternating +2048/-2048 -> mean_out=0, var_out=4194304 (1.0).
REQ-036 SHALL cover: LOG2_N=4, 16 samples of -32768 -> mean_out=-32768, var_out=0, with no overflow in sum or sumsq.
REQ-037 SHALL cover: valid_in toggled randomly with 3-cycle gaps, plus start pulsed during ACCUM -> results identical to the gapless run, start ignored, ce_out high only in ACCUM.
REQ-038 SHALL cover: i_reset=0 after 7 accepted samples -> outputs 0, no done; a new start then yields a correct full window.
REQ-039 SHALL cover: connection to the noise generator with default seeds, LOG2_N=12 -> |mean_out|<=205 (0.1) and var_out within 1.0+/-0.1 (3774873..4613734).

Source files
------------

// File: rtl/gng_stat_mon_pkg.sv
// Shared widths, formats and FSM encoding for the noise generator, its
// statistics monitor and the bench.
package gng_stat_mon_pkg;

    localparam int GNG_DW   = 16;            // sample width, s<16,11>
    localparam int GNG_FRAC = 11;            // fraction bits of a sample
    localparam int GNG_VW   = 32;            // variance width, u<32,22>
    localparam int GNG_SQW  = 2 * GNG_DW - 1; // exact square width, u<31,22>

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        MEAN  = 3'd2,
        SQ    = 3'd3,
        OUT   = 3'd4
    } stat_state_e;

endpackage

// File: rtl/gng_stat_acc.sv
// Sample counter, running sum and running sum of squares for one window
// of 2^LOG2_N accepted samples.
module gng_stat_acc
    import gng_stat_mon_pkg::*;
#(
    parameter int LOG2_N = 10
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 clear_i,
    input  logic                                 en_i,
    input  logic signed [GNG_DW-1:0]             data_i,
    output logic signed [GNG_DW+LOG2_N-1:0]      sum_o,
    output logic        [GNG_SQW+LOG2_N-1:0]     sumsq_o,
    output logic                                 last_o
);

    localparam int SW = GNG_DW + LOG2_N;
    localparam int QW = GNG_SQW + LOG2_N;

    logic        [LOG2_N-1:0]   cnt_q, cnt_d;
    logic signed [SW-1:0]       sum_q, sum_d;
    logic        [QW-1:0]       sumsq_q, sumsq_d;
    logic signed [2*GNG_DW-1:0] prod;

    // Always non-negative; the largest value is (-32768)^2 = 2^30.
    assign prod = data_i * data_i;

    always_comb begin
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        sumsq_d = sumsq_q;
        if (clear_i) begin
            cnt_d   = '0;
            sum_d   = '0;
            sumsq_d = '0;
        end else if (en_i) begin
            cnt_d   = cnt_q + 1'b1;
            sum_d   = sum_q + SW'(data_i);
            sumsq_d = sumsq_q + QW'($unsigned(prod));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            sum_q   <= '0;
            sumsq_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            sumsq_q <= sumsq_d;
        end
    end

    assign sum_o   = sum_q;
    assign sumsq_o = sumsq_q;
    assign last_o  = en_i && (cnt_q == '1);

endmodule

// File: rtl/gng_stat_mon.sv
// Measures mean and variance of a noise stream over one 2^LOG2_N-sample
// window per start request; results hold until the next done pulse.
module gng_stat_mon
    import gng_stat_mon_pkg::*;
#(
    parameter int LOG2_N = 10
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     start,
    input  logic                     valid_in,
    input  logic signed [GNG_DW-1:0] data_in,
    output logic                     ce_out,
    output logic                     busy,
    output logic                     done,
    output logic signed [GNG_DW-1:0] mean_out,
    output logic        [GNG_VW-1:0] var_out
);

    stat_state_e state_q, state_d;

    logic signed [GNG_DW+LOG2_N-1:0]  sum;
    logic        [GNG_SQW+LOG2_N-1:0] sumsq;
    logic                             last;
    logic                             accept;
    logic                             clear;

    logic signed [GNG_DW-1:0]   mean_q, mean_d;
    logic        [GNG_SQW-1:0]  msq_q, msq_d;
    logic signed [2*GNG_DW-1:0] sq_s;
    logic        [GNG_VW-1:0]   sq_w, msq_ext, var_d;
    logic signed [GNG_DW-1:0]   mean_out_q;
    logic        [GNG_VW-1:0]   var_out_q;

    assign accept = (state_q == ACCUM) && valid_in;
    assign clear  = (state_q == IDLE) && start;

    gng_stat_acc #(
        .LOG2_N (LOG2_N)
    ) u_acc (
        .clk_i   (i_clock),
        .rst_ni  (i_reset),
        .clear_i (clear),
        .en_i    (accept),
        .data_i  (data_in),
        .sum_o   (sum),
        .sumsq_o (sumsq),
        .last_o  (last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (last)  state_d = MEAN;
            MEAN:    state_d = SQ;
            SQ:      state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shifts only: the window length is a power of two.
    assign mean_d  = GNG_DW'(sum >>> LOG2_N);
    assign msq_d   = GNG_SQW'(sumsq >> LOG2_N);

    // Square and subtract share the SQ->OUT edge so the results land as OUT
    // is entered; a negative difference from the floored mean clamps to 0.
    assign sq_s    = mean_q * mean_q;
    assign sq_w    = $unsigned(sq_s);
    assign msq_ext = {1'b0, msq_q};
    assign var_d   = (msq_ext >= sq_w) ? (msq_ext - sq_w) : '0;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            mean_q     <= '0;
            msq_q      <= '0;
            mean_out_q <= '0;
            var_out_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == MEAN) begin
                mean_q <= mean_d;
                msq_q  <= msq_d;
            end
            if (state_q == SQ) begin
                mean_out_q <= mean_q;
                var_out_q  <= var_d;
            end
        end
    end

    assign ce_out   = (state_q == ACCUM);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == OUT);
    assign mean_out = mean_out_q;
    assign var_out  = var_out_q;

endmodule

// File: tb/tb_gng_stat_mon.sv
// Bench for gng_stat_mon at LOG2_N=4: directed vector table, reset abort
// sequence and random windows checked against an arithmetic reference.
module tb_gng_stat_mon;
    import gng_stat_mon_pkg::*;

    localparam int L = 4;
    localparam int N = 1 << L;

    logic                     i_clock = 1'b0;
    logic                     i_reset;
    logic                     start;
    logic                     valid_in;
    logic signed [GNG_DW-1:0] data_in;
    logic                     ce_out;
    logic                     busy;
    logic                     done;
    logic signed [GNG_DW-1:0] mean_out;
    logic        [GNG_VW-1:0] var_out;

    always #5 i_clock = ~i_clock;

    gng_stat_mon #(
        .LOG2_N (L)
    ) dut (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .start    (start),
        .valid_in (valid_in),
        .data_in  (data_in),
        .ce_out   (ce_out),
        .busy     (busy),
        .done     (done),
        .mean_out (mean_out),
        .var_out  (var_out)
    );

    typedef struct {
        int     a;      // even-indexed sample
        int     b;      // odd-indexed sample
        int     gap;    // max idle cycles before each sample
        bit     poke;   // pulse start while accumulating
        longint exp_m;
        longint exp_v;
    } vec_t;

    vec_t   tbl[7];
    int     smp[N];
    int     tests = 0;
    int     fails = 0;
    longint hold_m = 0;
    longint hold_v = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Reference: floor mean, mean of squares, difference clamped at zero.
    task automatic model(output longint m, output longint v);
        longint s = 0;
        longint q = 0;
        longint msq;
        for (int i = 0; i < N; i++) begin
            s += smp[i];
            q += longint'(smp[i]) * longint'(smp[i]);
        end
        m   = s >>> L;
        msq = q >> L;
        v   = msq - m * m;
        if (v < 0) v = 0;
    endtask

    task automatic run_window(input int gap_max, input bit poke,
                              output longint m, output longint v, output int lat);
        int bad = 0;
        @(negedge i_clock);
        start    = 1'b1;
        valid_in = 1'(($urandom & 1));
        data_in  = 16'($urandom);
        @(negedge i_clock);
        start = 1'b0;
        chk("hold_mean", longint'(mean_out), hold_m);
        chk("hold_var", longint'(var_out), hold_v);
        for (int i = 0; i < N; i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (g) begin
                valid_in = 1'b0;
                data_in  = 16'($urandom);
                start    = poke ? 1'(($urandom & 1)) : 1'b0;
                if (ce_out !== 1'b1 || busy !== 1'b1 || done !== 1'b0) bad++;
                @(negedge i_clock);
            end
            valid_in = 1'b1;
            data_in  = 16'(smp[i]);
            start    = poke ? 1'(($urandom & 1)) : 1'b0;
            if (ce_out !== 1'b1 || busy !== 1'b1 || done !== 1'b0) bad++;
            @(negedge i_clock);
        end
        // Tail samples still flagged valid must be ignored.
        start    = 1'b0;
        valid_in = 1'b1;
        data_in  = 16'($urandom);
        lat = 1;
        while (done !== 1'b1 && lat < 10) begin
            if (ce_out !== 1'b0 || busy !== 1'b1) bad++;
            @(negedge i_clock);
            data_in = 16'($urandom);
            lat++;
        end
        m = longint'(mean_out);
        v = longint'(var_out);
        start    = poke;
        valid_in = 1'b0;
        @(negedge i_clock);
        start = 1'b0;
        chk("ce_busy_window", bad, 0);
        chk("done_one_cycle", longint'(done), 0);
        chk("idle_after_out", longint'(busy), 0);
    endtask

    initial begin
        longint m, v, em, ev;
        int     lat;
        int     seen;

        tbl[0] = '{2048, 2048, 0, 1'b0, 2048, 0};
        tbl[1] = '{2048, -2048, 0, 1'b0, 0, 4194304};
        tbl[2] = '{-32768, -32768, 0, 1'b0, -32768, 0};
        tbl[3] = '{2048, 2048, 3, 1'b1, 2048, 0};
        tbl[4] = '{3, -3, 0, 1'b0, 0, 9};
        tbl[5] = '{-1, 0, 0, 1'b0, -1, 0};
        tbl[6] = '{32767, -32768, 2, 1'b0, -1, 1073709055};

        // Reset with start and valid active: reset must win.
        i_reset  = 1'b0;
        start    = 1'b1;
        valid_in = 1'b1;
        data_in  = 16'sd2048;
        repeat (3) @(negedge i_clock);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_ce", longint'(ce_out), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_mean", longint'(mean_out), 0);
        chk("rst_var", longint'(var_out), 0);
        start    = 1'b0;
        valid_in = 1'b0;
        i_reset  = 1'b1;
        @(negedge i_clock);

        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i < N; i++) smp[i] = (i % 2 == 0) ? tbl[t].a : tbl[t].b;
            run_window(tbl[t].gap, tbl[t].poke, m, v, lat);
            $display("[TB] vec %0d: a=%0d b=%0d gap=%0d mean=%0d var=%0d lat=%0d",
                     t, tbl[t].a, tbl[t].b, tbl[t].gap, m, v, lat);
            chk($sformatf("vec%0d_mean", t), m, tbl[t].exp_m);
            chk($sformatf("vec%0d_var", t), v, tbl[t].exp_v);
            chk($sformatf("vec%0d_latency", t), lat, 3);
            hold_m = tbl[t].exp_m;
            hold_v = tbl[t].exp_v;
        end

        // Abort a window after 7 accepted samples.
        @(negedge i_clock);
        start = 1'b1;
        @(negedge i_clock);
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            valid_in = 1'b1;
            data_in  = 16'sd2048;
            @(negedge i_clock);
        end
        i_reset = 1'b0;
        start   = 1'b1;
        @(negedge i_clock);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_ce", longint'(ce_out), 0);
        chk("abort_mean", longint'(mean_out), 0);
        chk("abort_var", longint'(var_out), 0);
        i_reset  = 1'b1;
        start    = 1'b0;
        valid_in = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge i_clock);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        chk("abort_no_done", seen, 0);
        $display("[TB] abort after 7 samples: busy=%0d mean=%0d var=%0d", busy, mean_out, var_out);
        hold_m = 0;
        hold_v = 0;

        // Random windows, the first right after the abort.
        for (int w = 0; w < 12; w++) begin
            int  gmax;
            bit  pk;
            for (int i = 0; i < N; i++) smp[i] = int'($urandom_range(0, 65535)) - 32768;
            if (w == 1) for (int i = 0; i < N; i++) smp[i] = int'($urandom_range(0, 4095)) - 2048;
            gmax = int'($urandom_range(0, 3));
            pk   = 1'(($urandom & 1));
            model(em, ev);
            run_window(gmax, pk, m, v, lat);
            $display("[TB] rand %0d: gap=%0d poke=%0d mean=%0d/%0d var=%0d/%0d lat=%0d",
                     w, gmax, pk, m, em, v, ev, lat);
            chk($sformatf("rand%0d_mean", w), m, em);
            chk($sformatf("rand%0d_var", w), v, ev);
            chk($sformatf("rand%0d_latency", w), lat, 3);
            hold_m = em;
            hold_v = ev;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
